// File: rtl/fft_display_ctrl_if.sv
// -----------------------------------------------------------------------------
// fft_display_ctrl_if
// Framebuffer block-write port driven by fft_display_ctrl.
//   wr_en    : write request (valid), driven by the master
//   wr_ready : framebuffer accepts the presented write this cycle
//   wr_addr  : block address, row*GRID_W + col
//   wr_color : RGB332 colour for wr_addr
// A write is transferred on a clock edge where wr_en && wr_ready.
// -----------------------------------------------------------------------------
interface fft_display_ctrl_if;
  logic        wr_en;
  logic        wr_ready;
  logic [19:0] wr_addr;
  logic [7:0]  wr_color;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_color,
    input  wr_ready
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_color,
    output wr_ready
  );
endinterface

// File: rtl/fft_display_ctrl.sv
// -----------------------------------------------------------------------------
// fft_display_ctrl
// Renders a 16-bin FFT spectrum as vertical bars into a block framebuffer.
// Bins are converted to clamped bar heights and captured into a shadow set
// on fft_done. Once a snapshot is pending the controller arms, waits for
// vblank_start, latches the shadow into the active set and streams every
// grid cell (red bar / white background) over the framebuffer write port.
//
// Ports:
//   clk          : system clock
//   reset        : synchronous, active-high reset
//   fft_bins     : NBINS signed 36-bit bin values, sampled on fft_done
//   fft_done     : one-cycle pulse, bins valid
//   vblank_start : one-cycle pulse at start of vertical blanking
//   wr           : framebuffer write port (master side)
//   busy         : high while armed or drawing
//   frame_done   : one-cycle pulse after the last cell is accepted
//   drop_cnt     : saturating count of snapshots overwritten before drawn
// -----------------------------------------------------------------------------
module fft_display_ctrl #(
  parameter int          GRID_W    = 32,
  parameter int          GRID_H    = 24,
  parameter int          NBINS     = 16,
  parameter int          MAG_SHIFT = 19,
  parameter logic [7:0]  BAR_COLOR = 8'hE0,
  parameter logic [7:0]  BG_COLOR  = 8'hFF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NBINS-1:0][35:0] fft_bins,
  input  logic                   fft_done,
  input  logic                   vblank_start,
  fft_display_ctrl_if.master     wr,
  output logic                   busy,
  output logic                   frame_done,
  output logic [7:0]             drop_cnt
);

  localparam int CPB = GRID_W / NBINS;       // grid columns per bin
  localparam int HW  = $clog2(GRID_H + 1);   // bar height width
  localparam int CW  = $clog2(GRID_W);
  localparam int RW  = $clog2(GRID_H);
  localparam int BW  = $clog2(NBINS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] DRAW = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  logic [1:0]                r_state;
  logic [NBINS-1:0][HW-1:0]  w_height;
  logic [NBINS-1:0][HW-1:0]  r_shadow;
  logic [NBINS-1:0][HW-1:0]  r_active;
  logic                      r_pending;
  logic [7:0]                r_drop_cnt;
  logic [RW-1:0]             r_row;
  logic [CW-1:0]             r_col;
  logic [RW-1:0]             w_row_nxt;
  logic [CW-1:0]             w_col_nxt;
  logic [BW-1:0]             w_bin_idx;
  logic [7:0]                w_cell_color;
  logic                      r_wr_en;
  logic [19:0]               r_wr_addr;
  logic [7:0]                r_wr_color;
  logic                      r_frame_done;
  logic                      w_accept;
  logic                      w_last;
  logic                      w_arm_go;

  // Bin to bar height: negative bins draw nothing, large bins clamp to the
  // full grid height.
  for (genvar gi = 0; gi < NBINS; gi++) begin : g_height
    logic [35:0] w_shift;
    assign w_shift = fft_bins[gi] >> MAG_SHIFT;
    assign w_height[gi] = fft_bins[gi][35]          ? '0 :
                          (w_shift > 36'(GRID_H))   ? HW'(GRID_H) :
                                                      HW'(w_shift);
  end

  assign w_accept = r_wr_en && wr.wr_ready;
  assign w_last   = (r_row == RW'(GRID_H - 1)) && (r_col == CW'(GRID_W - 1));
  assign w_arm_go = (r_state == ARM) && vblank_start;

  // Raster position of the cell presented after the current one is accepted.
  always_comb begin
    w_col_nxt = r_col + 1'b1;
    w_row_nxt = r_row;
    if (r_col == CW'(GRID_W - 1)) begin
      w_col_nxt = '0;
      w_row_nxt = r_row + 1'b1;
    end
  end

  assign w_bin_idx    = BW'(w_col_nxt / CW'(CPB));
  assign w_cell_color = (HW'(w_row_nxt) < r_active[w_bin_idx]) ? BAR_COLOR : BG_COLOR;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_shadow     <= '0;
      r_active     <= '0;
      r_pending    <= 1'b0;
      r_drop_cnt   <= 8'd0;
      r_row        <= '0;
      r_col        <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= 20'd0;
      r_wr_color   <= 8'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;

      // A snapshot arriving in the same cycle the old one is consumed is not
      // a drop: the old one goes to the active set, the new one stays pending.
      if (fft_done) begin
        r_shadow <= w_height;
        if (r_pending && !w_arm_go && (r_drop_cnt != 8'hFF))
          r_drop_cnt <= r_drop_cnt + 8'd1;
      end

      if (fft_done)
        r_pending <= 1'b1;
      else if (w_arm_go)
        r_pending <= 1'b0;

      case (r_state)
        IDLE: begin
          if (r_pending)
            r_state <= ARM;
        end
        ARM: begin
          if (vblank_start) begin
            r_active   <= r_shadow;
            r_row      <= '0;
            r_col      <= '0;
            r_wr_en    <= 1'b1;
            r_wr_addr  <= 20'd0;
            // Cell (0,0) is inside the bar whenever bin 0 is non-zero.
            r_wr_color <= (r_shadow[0] != '0) ? BAR_COLOR : BG_COLOR;
            r_state    <= DRAW;
          end
        end
        DRAW: begin
          if (w_accept) begin
            if (w_last) begin
              r_wr_en      <= 1'b0;
              r_wr_addr    <= 20'd0;
              r_wr_color   <= 8'd0;
              r_frame_done <= 1'b1;
              r_state      <= FIN;
            end else begin
              r_row      <= w_row_nxt;
              r_col      <= w_col_nxt;
              r_wr_addr  <= 20'(int'(w_row_nxt) * GRID_W + int'(w_col_nxt));
              r_wr_color <= w_cell_color;
            end
          end
        end
        FIN: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign wr.wr_en    = r_wr_en;
  assign wr.wr_addr  = r_wr_addr;
  assign wr.wr_color = r_wr_color;
  assign busy        = (r_state == ARM) || (r_state == DRAW);
  assign frame_done  = r_frame_done;
  assign drop_cnt    = r_drop_cnt;

endmodule
